// File: rtl/axi_err_slv.sv
// axi_err_slv: AXI4 responder that completes every burst with RESP; define AXI_ERR_SLV_ATOP_EN to answer atomics with an R burst too
module axi_err_slv #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 64,
    parameter int          ID_WIDTH   = 4,
    parameter int          USER_WIDTH = 1,
    parameter logic [1:0]  RESP       = 2'b11,
    parameter logic [63:0] RESP_DATA  = 64'hCA11_AB1E_BAD_CAB1E
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ID_WIDTH-1:0]   aw_id,
    input  logic [ADDR_WIDTH-1:0] aw_addr,
    input  logic [7:0]            aw_len,
    input  logic [2:0]            aw_size,
    input  logic [1:0]            aw_burst,
    input  logic                  aw_lock,
    input  logic [3:0]            aw_cache,
    input  logic [2:0]            aw_prot,
    input  logic [3:0]            aw_qos,
    input  logic [3:0]            aw_region,
    input  logic [5:0]            aw_atop,
    input  logic [USER_WIDTH-1:0] aw_user,
    input  logic                  aw_valid,
    output logic                  aw_ready,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [DATA_WIDTH/8-1:0] w_strb,
    input  logic                  w_last,
    input  logic [USER_WIDTH-1:0] w_user,
    input  logic                  w_valid,
    output logic                  w_ready,
    output logic [ID_WIDTH-1:0]   b_id,
    output logic [1:0]            b_resp,
    output logic [USER_WIDTH-1:0] b_user,
    output logic                  b_valid,
    input  logic                  b_ready,
    input  logic [ID_WIDTH-1:0]   ar_id,
    input  logic [ADDR_WIDTH-1:0] ar_addr,
    input  logic [7:0]            ar_len,
    input  logic [2:0]            ar_size,
    input  logic [1:0]            ar_burst,
    input  logic                  ar_lock,
    input  logic [3:0]            ar_cache,
    input  logic [2:0]            ar_prot,
    input  logic [3:0]            ar_qos,
    input  logic [3:0]            ar_region,
    input  logic [USER_WIDTH-1:0] ar_user,
    input  logic                  ar_valid,
    output logic                  ar_ready,
    output logic [ID_WIDTH-1:0]   r_id,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic [1:0]            r_resp,
    output logic                  r_last,
    output logic [USER_WIDTH-1:0] r_user,
    output logic                  r_valid,
    input  logic                  r_ready
);
    if (ADDR_WIDTH < 1 || DATA_WIDTH < 8 || ID_WIDTH < 1 || USER_WIDTH < 1) begin : g_bad_width
        $error("axi_err_slv: AXI widths must be positive");
    end

`ifdef AXI_ERR_SLV_ATOP_EN
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP, W_ATOP} w_state_e;
`else
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
`endif
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e            w_state;
    r_state_e            r_state;
    logic [ID_WIDTH-1:0] w_id;
    logic [7:0]          cnt;
    logic                atop_nxt;
    logic                unused_inputs;

    assign b_id   = w_id;
    assign b_resp = RESP;
    assign b_user = '0;
    assign r_data = DATA_WIDTH'(RESP_DATA);
    assign r_resp = RESP;
    assign r_user = '0;

    assign unused_inputs = ^{aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
                             aw_region, aw_atop, aw_user, w_data, w_strb, w_user, ar_addr, ar_size,
                             ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_region, ar_user};

`ifdef AXI_ERR_SLV_ATOP_EN
    logic       atop_req;
    logic       atop_bit;
    logic [7:0] w_len;
    assign atop_req = w_state == W_ATOP;
    // Predicts atop_req for the next cycle so ar_ready can drop before the read FSM sees it
    assign atop_nxt = (w_state == W_RESP && b_ready && atop_bit) || (atop_req && r_state != R_IDLE);
`else
    assign atop_nxt = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state  <= W_IDLE;
            aw_ready <= 1'b1;
            w_ready  <= 1'b0;
            b_valid  <= 1'b0;
            w_id     <= '0;
`ifdef AXI_ERR_SLV_ATOP_EN
            atop_bit <= 1'b0;
            w_len    <= '0;
`endif
        end else begin
            case (w_state)
                W_IDLE: if (aw_valid) begin
                    w_state  <= W_DATA;
                    aw_ready <= 1'b0;
                    w_ready  <= 1'b1;
                    w_id     <= aw_id;
`ifdef AXI_ERR_SLV_ATOP_EN
                    atop_bit <= aw_atop[5];
                    w_len    <= aw_len;
`endif
                end
                W_DATA: if (w_valid && w_last) begin
                    w_state <= W_RESP;
                    w_ready <= 1'b0;
                    b_valid <= 1'b1;
                end
                W_RESP: if (b_ready) begin
                    b_valid <= 1'b0;
`ifdef AXI_ERR_SLV_ATOP_EN
                    if (atop_bit) begin
                        w_state <= W_ATOP;
                    end else begin
                        w_state  <= W_IDLE;
                        aw_ready <= 1'b1;
                    end
`else
                    w_state  <= W_IDLE;
                    aw_ready <= 1'b1;
`endif
                end
`ifdef AXI_ERR_SLV_ATOP_EN
                W_ATOP: if (r_state == R_IDLE) begin
                    w_state  <= W_IDLE;
                    aw_ready <= 1'b1;
                end
`endif
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= R_IDLE;
            ar_ready <= 1'b1;
            r_valid  <= 1'b0;
            r_id     <= '0;
            r_last   <= 1'b1;
            cnt      <= '0;
        end else begin
            case (r_state)
                R_IDLE:
`ifdef AXI_ERR_SLV_ATOP_EN
                    if (atop_req) begin
                        r_state  <= R_DATA;
                        r_valid  <= 1'b1;
                        r_id     <= w_id;
                        cnt      <= w_len;
                        r_last   <= w_len == 8'd0;
                        ar_ready <= 1'b0;
                    end else
`endif
                    if (ar_valid && ar_ready) begin
                        r_state  <= R_DATA;
                        r_valid  <= 1'b1;
                        r_id     <= ar_id;
                        cnt      <= ar_len;
                        r_last   <= ar_len == 8'd0;
                        ar_ready <= 1'b0;
                    end else begin
                        ar_ready <= !atop_nxt;
                    end
                R_DATA: if (r_ready) begin
                    if (cnt == 8'd0) begin
                        r_state  <= R_IDLE;
                        r_valid  <= 1'b0;
                        ar_ready <= !atop_nxt;
                    end else begin
                        cnt    <= cnt - 8'd1;
                        r_last <= cnt == 8'd1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_err_slv.sv
// tb_axi_err_slv: directed vector bench for axi_err_slv, covering writes, reads, backpressure, reset and atomics
module tb_axi_err_slv;
    localparam logic [63:0] RD = 64'hCA11_AB1E_BAD_CAB1E;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [3:0]  aw_id = '0, ar_id = '0, b_id, r_id;
    logic [31:0] aw_addr = '0, ar_addr = '0;
    logic [7:0]  aw_len = '0, ar_len = '0, w_strb = '0;
    logic [5:0]  aw_atop = '0;
    logic [63:0] w_data = '0, r_data;
    logic [1:0]  b_resp, r_resp;
    logic        aw_valid = 0, w_valid = 0, w_last = 0, b_ready = 0, ar_valid = 0, r_ready = 0;
    logic        aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last;
    logic        b_user, r_user;
    int          checks = 0, failures = 0, cyc = 0;

    axi_err_slv #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4), .USER_WIDTH(1)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(3'd3), .aw_burst(2'd1),
        .aw_lock(1'b0), .aw_cache(4'd0), .aw_prot(3'd0), .aw_qos(4'd0), .aw_region(4'd0),
        .aw_atop(aw_atop), .aw_user(1'b0), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_user(1'b0), .w_valid(w_valid),
        .w_ready(w_ready), .b_id(b_id), .b_resp(b_resp), .b_user(b_user), .b_valid(b_valid),
        .b_ready(b_ready), .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(3'd3),
        .ar_burst(2'd1), .ar_lock(1'b0), .ar_cache(4'd0), .ar_prot(3'd0), .ar_qos(4'd0),
        .ar_region(4'd0), .ar_user(1'b0), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_user(r_user),
        .r_valid(r_valid), .r_ready(r_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic wr(input logic [3:0] id, input logic [7:0] len, input logic [5:0] atop,
                      input int early, input int hold, input logic aw_after,
                      input logic [3:0] exp_id, output int lat);
        int t, b, c0;
        bit aw_hi = 0, early_bad = 0, hold_ok = 1;
        w_valid = early > 0;
        w_last  = len == 0;
        for (int i = 0; i < early; i++) begin
            if (w_ready) early_bad = 1;
            @(negedge clk);
        end
        aw_id = id; aw_len = len; aw_atop = atop; aw_valid = 1;
        t = 0;
        while (!aw_ready && t < 50) begin @(negedge clk); t++; end
        chk("aw_accept", aw_ready, 1);
        c0 = cyc;
        @(negedge clk);
        aw_valid = 0; aw_atop = 0;
        b = 0; t = 0;
        while (b <= len && t < 500) begin
            w_valid = 1;
            w_last  = b == len;
            if (aw_ready) aw_hi = 1;
            if (w_ready) b++;
            @(negedge clk);
            t++;
        end
        w_valid = 0; w_last = 0;
        chk("w_beats", b, len + 1);
        b_ready = 0;
        if (hold > 0) begin
            aw_valid = 1; aw_id = ~id;
        end
        for (int i = 0; i < hold; i++) begin
            if (!b_valid || b_id !== exp_id) hold_ok = 0;
            if (aw_ready) aw_hi = 1;
            @(negedge clk);
        end
        aw_valid = 0;
        b_ready = 1;
        t = 0;
        while (!b_valid && t < 50) begin
            if (aw_ready) aw_hi = 1;
            @(negedge clk);
            t++;
        end
        lat = cyc - c0;
        chk("b_valid", b_valid, 1);
        chk("b_id", b_id, exp_id);
        chk("b_resp", b_resp, 2'b11);
        chk("b_user", b_user, 0);
        @(negedge clk);
        b_ready = 0;
        chk("b_once", b_valid, 0);
        chk("aw_ready_after_b", aw_ready, aw_after);
        chk("aw_ready_low_during_write", aw_hi, 0);
        if (hold > 0) chk("b_hold_stable", hold_ok, 1);
        if (early > 0) chk("w_wait_for_aw", early_bad, 0);
    endtask

    task automatic rd(input logic [3:0] id, input logic [7:0] len, input bit bp,
                      input logic [3:0] exp_id, input int exp_n);
        int t, beats;
        bit held = 0, id_ok = 1, last_ok = 1, data_ok = 1, stab_ok = 1;
        logic [3:0] pid;
        logic plast;
        ar_id = id; ar_len = len; ar_valid = 1;
        t = 0;
        while (!ar_ready && t < 50) begin @(negedge clk); t++; end
        chk("ar_accept", ar_ready, 1);
        @(negedge clk);
        ar_valid = 0;
        chk("r_first_cycle", r_valid, 1);
        beats = 0; t = 0;
        while (beats < exp_n && t < 3000) begin
            r_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (r_valid) begin
                if (held && (r_id !== pid || r_last !== plast || r_data !== RD || r_resp !== 2'b11)) stab_ok = 0;
                if (r_id !== exp_id) id_ok = 0;
                if (r_data !== RD || r_resp !== 2'b11 || r_user !== 1'b0) data_ok = 0;
                if (r_last !== (beats == exp_n - 1)) last_ok = 0;
                held = !r_ready; pid = r_id; plast = r_last;
                if (r_ready) beats++;
            end
            @(negedge clk);
            t++;
        end
        r_ready = 0;
        chk("r_beats", beats, exp_n);
        chk("r_id", id_ok, 1);
        chk("r_last", last_ok, 1);
        chk("r_payload", data_ok, 1);
        chk("r_stable", stab_ok, 1);
        chk("r_done", r_valid, 0);
    endtask

    typedef struct {
        bit         is_rd;
        logic [3:0] id;
        logic [7:0] len;
        int         early;
        int         hold;
        bit         bp;
        logic [3:0] exp_id;
        int         exp_n;
        int         exp_lat;
    } vec_t;

    initial begin
        vec_t       vecs[7];
        int         lat, lat2;
        logic       go;
        logic [4:0] q[$], exp_q[$];
        vecs[0] = '{0, 4'd5, 8'd3, 0, 0, 0, 4'd5, 0, 0};
        vecs[1] = '{0, 4'd0, 8'd0, 1, 0, 0, 4'd0, 0, 2};
        vecs[2] = '{0, 4'd15, 8'd0, 0, 10, 0, 4'd15, 0, 0};
        vecs[3] = '{1, 4'd2, 8'd255, 0, 0, 1, 4'd2, 256, 0};
        vecs[4] = '{1, 4'd3, 8'd0, 0, 0, 0, 4'd3, 1, 0};
        vecs[5] = '{1, 4'd9, 8'd4, 0, 0, 1, 4'd9, 5, 0};
        vecs[6] = '{0, 4'd12, 8'd7, 2, 3, 0, 4'd12, 0, 0};

        repeat (2) @(negedge clk);
        chk("rst_aw_ready", aw_ready, 1);
        chk("rst_ar_ready", ar_ready, 1);
        chk("rst_w_ready", w_ready, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_r_valid", r_valid, 0);
        rst_ni = 1;
        @(negedge clk);

        foreach (vecs[i]) begin
            if (vecs[i].is_rd) rd(vecs[i].id, vecs[i].len, vecs[i].bp, vecs[i].exp_id, vecs[i].exp_n);
            else begin
                wr(vecs[i].id, vecs[i].len, 6'd0, vecs[i].early, vecs[i].hold, 1'b1, vecs[i].exp_id, lat);
                if (vecs[i].exp_lat != 0) chk("w_latency", lat, vecs[i].exp_lat);
            end
            @(negedge clk);
        end

        // AW and AR in the same cycle, with W data waiting three cycles before AW
        fork
            wr(4'd1, 8'd0, 6'd0, 3, 0, 1'b1, 4'd1, lat2);
            begin
                repeat (3) @(negedge clk);
                rd(4'd7, 8'd1, 1'b0, 4'd7, 2);
            end
        join
        @(negedge clk);

        // Reset in the middle of a read burst
        ar_id = 4'd6; ar_len = 8'd10; ar_valid = 1;
        @(negedge clk);
        ar_valid = 0; r_ready = 1;
        repeat (3) @(negedge clk);
        chk("mid_burst_r_valid", r_valid, 1);
        rst_ni = 0;
        r_ready = 0;
        #1;
        chk("async_rst_r_valid", r_valid, 0);
        chk("async_rst_aw_ready", aw_ready, 1);
        chk("async_rst_ar_ready", ar_ready, 1);
        @(negedge clk);
        rst_ni = 1;
        @(negedge clk);
        rd(4'd3, 8'd0, 1'b0, 4'd3, 1);
        @(negedge clk);

        // Atomic write followed by a pending AR
`ifdef AXI_ERR_SLV_ATOP_EN
        wr(4'd4, 8'd1, 6'b100000, 0, 0, 1'b0, 4'd4, lat);
        exp_q = '{5'b0100_0, 5'b0100_1, 5'b1000_1};
`else
        wr(4'd4, 8'd1, 6'b100000, 0, 0, 1'b1, 4'd4, lat);
        exp_q = '{5'b1000_1};
`endif
        ar_id = 4'd8; ar_len = 8'd0; ar_valid = 1; r_ready = 1;
`ifdef AXI_ERR_SLV_ATOP_EN
        chk("ar_blocked_by_atop", ar_ready, 0);
`endif
        for (int i = 0; i < 20; i++) begin
            go = ar_valid && ar_ready;
            if (r_valid) q.push_back({r_id, r_last});
            @(negedge clk);
            if (go) ar_valid = 0;
        end
        r_ready = 0; ar_valid = 0;
        chk("atop_r_count", q.size(), exp_q.size());
        foreach (exp_q[i]) if (i < q.size()) chk("atop_r_beat", q[i], exp_q[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
